// File: rtl/interleaver_pp.sv
// interleaver_pp: ping-pong OFDM block interleaver for QPSK/16-QAM/64-QAM blocks.
// Define INTERLEAVER_STATS_EN to add the blk_count and mode_err status outputs.
module interleaver_pp #(
  parameter int N_SC = 96,
  parameter int D = 16,
  parameter int NCBPS_MAX = N_SC * 6,
  parameter int AW = $clog2(NCBPS_MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  input  logic          in_data,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          out_data,
  output logic          out_last,
  output logic [1:0]    out_mode,
  output logic [AW-1:0] out_index
`ifdef INTERLEAVER_STATS_EN
  ,
  output logic [15:0]   blk_count,
  output logic          mode_err
`endif
);
  localparam int KW = (D > 1) ? $clog2(D) : 1;
  localparam logic [AW-1:0] ST2 = AW'(N_SC * 2 / D);
  localparam logic [AW-1:0] ST4 = AW'(N_SC * 4 / D);
  localparam logic [AW-1:0] ST6 = AW'(N_SC * 6 / D);
  localparam logic [2:0] SM4 = 3'((N_SC * 4 / D) % 2);
  localparam logic [2:0] SM6 = 3'((N_SC * 6 / D) % 3);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bst_t;
  function automatic logic [AW-1:0] nlast(input logic [1:0] md);
    return (md == 2'd2) ? AW'(N_SC * 6 - 1) : (md == 2'd1) ? AW'(N_SC * 4 - 1) : AW'(N_SC * 2 - 1);
  endfunction
  function automatic logic [2:0] modinc(input logic [2:0] a, input logic [2:0] b, input logic [2:0] s);
    logic [2:0] t;
    t = a + b;
    return (t >= s) ? t - s : t;
  endfunction
  bst_t st_q [2];
  bst_t st_d [2];
  logic [1:0] bmode_q [2];
  logic [1:0] bmode_d [2];
  logic wb_q, wb_d, rb_q, rb_d;
  logic [AW-1:0] k_q, k_d, kdiv_q, kdiv_d, m_q, m_d, r_q, r_d;
  logic [KW-1:0] kmod_q, kmod_d;
  logic [2:0] rm_q, rm_d, rk_q, rk_d, kdr_q, kdr_d;
  logic a_valid_q, a_valid_d, a_data_q, a_data_d, a_last_q, a_last_d;
  logic [AW-1:0] a_idx_q, a_idx_d;
  logic [1:0] a_mode_q, a_mode_d;
  logic out_valid_q, out_valid_d, out_data_q, out_data_d, out_last_q, out_last_d;
  logic [AW-1:0] out_index_q, out_index_d;
  logic [1:0] out_mode_q, out_mode_d;
  logic [NCBPS_MAX-1:0] mem_q [2];
  logic [1:0] mode_in, cmode;
  logic [2:0] s, stepm, kdr_inc;
  logic [AW-1:0] step, j;
  logic wr, wlast, kwrap, b_ready, a_ready, rd, rlast;
`ifdef INTERLEAVER_STATS_EN
  logic [15:0] blk_count_q, blk_count_d;
  logic mode_err_q, mode_err_d;
`endif
  // m tracks (Ncbps/D)*(k mod D) + k div D; rm, rk, kdr are m, k mod D and k div D reduced mod s
  always_comb begin
    mode_in = (mode == 2'd3) ? 2'd0 : mode;
    cmode = (k_q == '0) ? mode_in : bmode_q[wb_q];
    s = (cmode == 2'd2) ? 3'd3 : (cmode == 2'd1) ? 3'd2 : 3'd1;
    step = (cmode == 2'd2) ? ST6 : (cmode == 2'd1) ? ST4 : ST2;
    stepm = (cmode == 2'd2) ? SM6 : (cmode == 2'd1) ? SM4 : 3'd0;
    j = m_q - AW'(rm_q) + AW'(modinc(rm_q, s - rk_q, s));
    in_ready = !reset && (st_q[wb_q] == EMPTY || st_q[wb_q] == FILLING);
    wr = in_valid && in_ready;
    wlast = k_q == nlast(cmode);
    kwrap = kmod_q == KW'(D - 1);
    kdr_inc = modinc(kdr_q, 3'd1, s);
    b_ready = !out_valid_q || out_ready;
    a_ready = !a_valid_q || b_ready;
    rd = a_ready && (st_q[rb_q] == FULL || st_q[rb_q] == DRAINING);
    rlast = r_q == nlast(bmode_q[rb_q]);
    st_d = st_q;
    bmode_d = bmode_q;
    wb_d = wb_q;
    rb_d = rb_q;
    k_d = k_q;
    kmod_d = kmod_q;
    kdiv_d = kdiv_q;
    m_d = m_q;
    rm_d = rm_q;
    rk_d = rk_q;
    kdr_d = kdr_q;
    r_d = r_q;
    a_valid_d = a_valid_q;
    a_data_d = a_data_q;
    a_last_d = a_last_q;
    a_idx_d = a_idx_q;
    a_mode_d = a_mode_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_index_d = out_index_q;
    out_mode_d = out_mode_q;
    if (wr) begin
      k_d = wlast ? '0 : k_q + 1'b1;
      kmod_d = (wlast || kwrap) ? '0 : kmod_q + 1'b1;
      kdiv_d = wlast ? '0 : kwrap ? kdiv_q + 1'b1 : kdiv_q;
      kdr_d = wlast ? '0 : kwrap ? kdr_inc : kdr_q;
      rk_d = (wlast || kwrap) ? '0 : modinc(rk_q, 3'd1, s);
      m_d = wlast ? '0 : kwrap ? kdiv_q + 1'b1 : m_q + step;
      rm_d = wlast ? '0 : kwrap ? kdr_inc : modinc(rm_q, stepm, s);
      st_d[wb_q] = wlast ? FULL : FILLING;
      bmode_d[wb_q] = (k_q == '0) ? mode_in : bmode_q[wb_q];
      wb_d = wlast ? ~wb_q : wb_q;
    end
    if (b_ready) begin
      out_valid_d = a_valid_q;
      out_data_d = a_valid_q ? a_data_q : out_data_q;
      out_last_d = a_valid_q ? a_last_q : out_last_q;
      out_index_d = a_valid_q ? a_idx_q : out_index_q;
      out_mode_d = a_valid_q ? a_mode_q : out_mode_q;
    end
    if (a_ready) a_valid_d = rd;
    if (rd) begin
      a_data_d = mem_q[rb_q][r_q];
      a_idx_d = r_q;
      a_last_d = rlast;
      a_mode_d = bmode_q[rb_q];
      r_d = rlast ? '0 : r_q + 1'b1;
      st_d[rb_q] = rlast ? EMPTY : DRAINING;
      rb_d = rlast ? ~rb_q : rb_q;
    end
`ifdef INTERLEAVER_STATS_EN
    blk_count_d = (out_valid_q && out_ready && out_last_q) ? blk_count_q + 16'd1 : blk_count_q;
    mode_err_d = mode_err_q || (wr && k_q != '0 && mode_in != bmode_q[wb_q]);
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
      bmode_q[0] <= 2'd0;
      bmode_q[1] <= 2'd0;
      wb_q <= 1'b0;
      rb_q <= 1'b0;
      k_q <= '0;
      kmod_q <= '0;
      kdiv_q <= '0;
      m_q <= '0;
      rm_q <= '0;
      rk_q <= '0;
      kdr_q <= '0;
      r_q <= '0;
      a_valid_q <= 1'b0;
      a_data_q <= 1'b0;
      a_last_q <= 1'b0;
      a_idx_q <= '0;
      a_mode_q <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q <= 1'b0;
      out_last_q <= 1'b0;
      out_index_q <= '0;
      out_mode_q <= 2'd0;
`ifdef INTERLEAVER_STATS_EN
      blk_count_q <= 16'd0;
      mode_err_q <= 1'b0;
`endif
    end else begin
      st_q <= st_d;
      bmode_q <= bmode_d;
      wb_q <= wb_d;
      rb_q <= rb_d;
      k_q <= k_d;
      kmod_q <= kmod_d;
      kdiv_q <= kdiv_d;
      m_q <= m_d;
      rm_q <= rm_d;
      rk_q <= rk_d;
      kdr_q <= kdr_d;
      r_q <= r_d;
      a_valid_q <= a_valid_d;
      a_data_q <= a_data_d;
      a_last_q <= a_last_d;
      a_idx_q <= a_idx_d;
      a_mode_q <= a_mode_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_index_q <= out_index_d;
      out_mode_q <= out_mode_d;
`ifdef INTERLEAVER_STATS_EN
      blk_count_q <= blk_count_d;
      mode_err_q <= mode_err_d;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wb_q][j] <= in_data;
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign out_index = out_index_q;
  assign out_mode = out_mode_q;
`ifdef INTERLEAVER_STATS_EN
  assign blk_count = blk_count_q;
  assign mode_err = mode_err_q;
`endif
endmodule

// File: tb/tb_interleaver_pp.sv
// tb_interleaver_pp: directed checks of interleaver_pp permutation, handshakes, latency and reset.
module tb_interleaver_pp;
  localparam int AW = 10;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] mode = 2'd0;
  logic in_valid = 1'b0, in_data = 1'b0, in_ready, out_ready = 1'b0;
  logic out_valid, out_data, out_last;
  logic [1:0] out_mode;
  logic [AW-1:0] out_index;
  int checks = 0, errors = 0, cyc = 0, stall_err = 0;
  bit or_man = 1'b0, rand_en = 1'b0;
  bit blk [576];
  typedef struct {bit d; int idx; bit last; int md; int cyc;} rec_t;
  rec_t q[$];
  bit pv, pr, pd, pl;
  int pi, pm;

  always #5 clk = ~clk;

  interleaver_pp dut (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_mode(out_mode), .out_index(out_index)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #2;
    out_ready = rand_en ? bit'($urandom_range(0, 1)) : or_man;
  end

  always @(negedge clk) begin
    if (reset) pv = 1'b0;
    else begin
      if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl ||
          int'(out_index) != pi || int'(out_mode) != pm)) stall_err++;
      if (out_valid && out_ready) q.push_back('{out_data, int'(out_index), out_last, int'(out_mode), cyc});
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      pi = int'(out_index); pm = int'(out_mode);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int jf(int md, int k);
    int ncpc, n, s, m;
    ncpc = (md == 1) ? 4 : (md == 2) ? 6 : 2;
    n = 96 * ncpc;
    s = ncpc / 2;
    m = (n / 16) * (k % 16) + k / 16;
    return s * (m / s) + ((m + n - (16 * m) / n) % s);
  endfunction

  function automatic logic [575:0] expv(int md, int n);
    logic [575:0] e = '0;
    for (int k = 0; k < n; k++) e[jf(md, k)] = blk[k];
    return e;
  endfunction

  task automatic fill(input bit rnd, input int hot);
    for (int k = 0; k < 576; k++) blk[k] = rnd ? bit'($urandom_range(0, 1)) : (k == hot);
  endtask

  task automatic wr_block(input int md, input int alt, input int n, output int drops);
    int k = 0, g = 0;
    bit acc;
    drops = 0;
    while (k < n && g < n * 100 + 2000) begin
      mode = 2'((k == 0) ? md : alt);
      in_valid = 1'b1;
      in_data = blk[k];
      @(negedge clk);
      acc = in_ready;
      if (!acc) drops++;
      @(posedge clk);
      #1;
      if (acc) k++;
      g++;
    end
    in_valid = 1'b0;
    checks++;
    if (k < n) begin errors++; $display("FAIL wr_timeout accepted %0d required %0d", k, n); end
  endtask

  task automatic collect(input int n, output logic [575:0] v, output int lastpos, output int md,
                         output int idxerr, output int gaps);
    int g = 0, pc = 0;
    rec_t r;
    v = '0; lastpos = -1; md = -1; idxerr = 0; gaps = 0;
    while (q.size() < n && g < 20000) begin @(posedge clk); #1; g++; end
    checks++;
    if (q.size() < n) begin
      errors++;
      $display("FAIL collect_timeout got %0d bits required %0d", q.size(), n);
      return;
    end
    md = q[0].md;
    for (int i = 0; i < n; i++) begin
      r = q.pop_front();
      if (r.idx >= 0 && r.idx < 576) v[r.idx] = r.d;
      if (r.idx != i || r.md != md || r.last != (i == n - 1)) idxerr++;
      if (r.last && lastpos < 0) lastpos = i;
      if (i > 0 && r.cyc != pc + 1) gaps++;
      pc = r.cyc;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_last, out_mode, out_index} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h required 0", {out_valid, out_data, out_last, out_mode, out_index});
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b required 0", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_qpsk;
    logic [575:0] v, e;
    int lp, md, ie, gp, dr;
    logic v0, v1, v2;
    or_man = 1'b1;
    fill(0, 1);
    wr_block(0, 0, 192, dr);
    @(negedge clk); v0 = out_valid;
    @(negedge clk); v1 = out_valid;
    @(negedge clk); v2 = out_valid;
    @(posedge clk); #1;
    checks++;
    if ({v0, v1, v2} !== 3'b001) begin errors++; $display("FAIL latency out_valid after edges 0..2 got %b required 001", {v0, v1, v2}); end
    collect(192, v, lp, md, ie, gp);
    e = '0; e[12] = 1'b1;
    checks++;
    if (v !== e) begin errors++; $display("FAIL qpsk_k1 got %h required %h", v, e); end
    checks++;
    if (lp != 191) begin errors++; $display("FAIL qpsk_last got %0d required 191", lp); end
    checks++;
    if (md != 0 || ie != 0) begin errors++; $display("FAIL qpsk_fields mode %0d idxerr %0d required 0 0", md, ie); end
    fill(0, 16);
    wr_block(0, 0, 192, dr);
    collect(192, v, lp, md, ie, gp);
    e = '0; e[1] = 1'b1;
    checks++;
    if (v !== e) begin errors++; $display("FAIL qpsk_k16 got %h required %h", v, e); end
  endtask

  task automatic test_qam;
    logic [575:0] v, e;
    int lp, md, ie, gp, dr;
    fill(0, 1);
    wr_block(1, 1, 384, dr);
    collect(384, v, lp, md, ie, gp);
    e = '0; e[25] = 1'b1;
    checks++;
    if (v !== e) begin errors++; $display("FAIL qam16_k1 got %h required %h", v, e); end
    checks++;
    if (lp != 383 || md != 1 || ie != 0) begin errors++; $display("FAIL qam16_fields last %0d mode %0d idxerr %0d required 383 1 0", lp, md, ie); end
    wr_block(2, 2, 576, dr);
    collect(576, v, lp, md, ie, gp);
    e = '0; e[38] = 1'b1;
    checks++;
    if (v !== e) begin errors++; $display("FAIL qam64_k1 got %h required %h", v, e); end
    checks++;
    if (lp != 575 || md != 2 || ie != 0) begin errors++; $display("FAIL qam64_fields last %0d mode %0d idxerr %0d required 575 2 0", lp, md, ie); end
  endtask

  task automatic test_back_to_back;
    logic [575:0] e [3];
    logic [575:0] v;
    int lp, md, ie, gp, dr, drops = 0;
    int ns [3] = '{192, 384, 576};
    for (int b = 0; b < 3; b++) begin
      fill(1, 0);
      wr_block(b, b, ns[b], dr);
      drops += dr;
      e[b] = expv(b, ns[b]);
    end
    checks++;
    if (drops != 0) begin errors++; $display("FAIL b2b_in_ready_drops got %0d required 0", drops); end
    for (int b = 0; b < 3; b++) begin
      collect(ns[b], v, lp, md, ie, gp);
      checks++;
      if (v !== e[b] || md != b || ie != 0 || gp != 0) begin
        errors++; $display("FAIL b2b_block%0d mode %0d idxerr %0d gaps %0d required mode %0d, data ok %b", b, md, ie, gp, b, v === e[b]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [575:0] e0, e1, v;
    int lp, md, ie, gp, dr, drops = 0, c = 0;
    or_man = 1'b0;
    stall_err = 0;
    fill(1, 0); wr_block(0, 0, 192, dr); drops += dr; e0 = expv(0, 192);
    fill(1, 0); wr_block(0, 0, 192, dr); drops += dr; e1 = expv(0, 192);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || drops != 0) begin errors++; $display("FAIL bp_in_ready got %b drops %0d required 0 0", in_ready, drops); end
    checks++;
    if (out_valid !== 1'b1 || out_index !== '0) begin errors++; $display("FAIL bp_hold valid %b index %0d required 1 0", out_valid, out_index); end
    @(posedge clk); #1;
    or_man = 1'b1;
    do begin
      @(posedge clk); #1; c++;
      @(negedge clk);
    end while (!in_ready && c < 1000);
    @(posedge clk); #1;
    checks++;
    if (c != 190) begin errors++; $display("FAIL bp_release edges got %0d required 190", c); end
    collect(192, v, lp, md, ie, gp);
    checks++;
    if (v !== e0 || ie != 0) begin errors++; $display("FAIL bp_block0 idxerr %0d data got %h required %h", ie, v, e0); end
    collect(192, v, lp, md, ie, gp);
    checks++;
    if (v !== e1 || ie != 0) begin errors++; $display("FAIL bp_block1 idxerr %0d data got %h required %h", ie, v, e1); end
    checks++;
    if (stall_err != 0) begin errors++; $display("FAIL bp_stall_stable got %0d changes required 0", stall_err); end
  endtask

  task automatic test_random_stall;
    logic [575:0] e [3];
    logic [575:0] v;
    int lp, md, ie, gp, dr;
    int ns [3] = '{192, 384, 576};
    stall_err = 0;
    rand_en = 1'b1;
    for (int b = 2; b >= 0; b--) begin
      fill(1, 0);
      wr_block(b, (b + 1) % 3, ns[b], dr);
      e[b] = expv(b, ns[b]);
    end
    for (int b = 2; b >= 0; b--) begin
      collect(ns[b], v, lp, md, ie, gp);
      checks++;
      if (v !== e[b] || md != b || ie != 0) begin
        errors++; $display("FAIL rs_block%0d mode %0d idxerr %0d required mode %0d, data got %h required %h", b, md, ie, b, v, e[b]);
      end
    end
    rand_en = 1'b0;
    or_man = 1'b1;
    checks++;
    if (stall_err != 0) begin errors++; $display("FAIL rs_stall_stable got %0d changes required 0", stall_err); end
  endtask

  task automatic test_async_reset;
    logic [575:0] e, v;
    int lp, md, ie, gp, dr;
    or_man = 1'b0;
    fill(1, 0); wr_block(0, 0, 192, dr);
    repeat (3) begin @(posedge clk); #1; end
    fill(1, 0); wr_block(1, 1, 100, dr);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %b required 1", out_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, out_last, out_mode, out_index} !== '0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL ar_async_outputs got %h in_ready %b required 0 0", {out_valid, out_data, out_last, out_mode, out_index}, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    or_man = 1'b1;
    fill(1, 0); wr_block(0, 0, 192, dr); e = expv(0, 192);
    collect(192, v, lp, md, ie, gp);
    checks++;
    if (v !== e || ie != 0 || lp != 191) begin errors++; $display("FAIL ar_fresh_block idxerr %0d last %0d data got %h required %h", ie, lp, v, e); end
    repeat (20) begin @(posedge clk); #1; end
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL ar_no_stale extra %0d valid %b required 0 0", q.size(), out_valid); end
  endtask

  initial begin
    test_reset();
    test_qpsk();
    test_qam();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
